// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one-cycle latency.
module sync_fifo_flags #(
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 16,
  parameter int ALMOST_FULL_THRESH  = 14,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          write_enable,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          read_enable,
  output logic [DATA_WIDTH-1:0]         read_data,
  output logic                          read_valid,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          err_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // Flags come only from the registered count, so enables never reach them combinationally.
  assign fifo_empty   = (r_count == '0);
  assign fifo_full    = (r_count == CW'(FIFO_DEPTH));
  assign almost_empty = (r_count <= CW'(ALMOST_EMPTY_THRESH));
  assign almost_full  = (r_count >= CW'(ALMOST_FULL_THRESH));
  assign fifo_count   = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  assign w_wr_ok = write_enable && !fifo_full;
  assign w_rd_ok = read_enable && !fifo_empty;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr_ok) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
    end else if (w_rd_ok) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write_enable && fifo_full) begin
        r_overflow <= 1'b1;
      end else if (err_clear) begin
        r_overflow <= 1'b0;
      end
      if (read_enable && fifo_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clear) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented whenever the FIFO holds data; a read pops it.
  assign read_data  = fifo_empty ? '0 : r_mem[r_rd_ptr];
  assign read_valid = !fifo_empty;
`else
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_read_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_read_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign read_data  = r_read_data;
  assign read_valid = r_read_valid;
`endif

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO with registered occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It replaces fixed-width-pointer FIFOs in datapath buffering between producer and consumer stages in the same clock domain. Read-side behaviour (registered read or first-word-fall-through) is selected at compile time.

## Interface
- DATA_WIDTH, 8, data word width in bits (≥1)
- FIFO_DEPTH, 16, number of entries; power of two, ≥4
- ALMOST_FULL_THRESH, 14, almost_full asserts when count ≥ this value (1..FIFO_DEPTH)
- ALMOST_EMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (0..FIFO_DEPTH-1)
- Derived, not a parameter: AW = $clog2(FIFO_DEPTH) for pointers; count width AW+1

- clk  input  1  clock; all state changes on rising edge
- reset_n  input  1  asynchronous active-low reset
- write_enable  input  1  write request
- write_data  input  DATA_WIDTH  write word
- read_enable  input  1  read request
- read_data  output  DATA_WIDTH  read word
- read_valid  output  1  read_data holds a valid word (meaning per Configuration)
- fifo_empty  output  1  count == 0
- fifo_full  output  1  count == FIFO_DEPTH
- almost_empty  output  1  count ≤ ALMOST_EMPTY_THRESH
- almost_full  output  1  count ≥ ALMOST_FULL_THRESH
- fifo_count  output  AW+1  current occupancy, 0..FIFO_DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty
- err_clear  input  1  synchronous clear of overflow/underflow

## Operation
- Write accepted (wr_ok) iff write_enable && !fifo_full; stores write_data at wr_ptr, wr_ptr += 1.
- Read accepted (rd_ok) iff read_enable && !fifo_empty; rd_ptr += 1.
- Acceptance uses flags from start of cycle: full + both requests → read accepted, write rejected; empty + both → write accepted, read rejected.
- Count: +1 on wr_ok only, −1 on rd_ok only, unchanged when both or neither. One count register, one always block owns it.
- Pointers AW bits, wrap naturally from FIFO_DEPTH-1 to 0; no pointer ever driven from two processes.
- All flags decoded from registered fifo_count only; no combinational path from enables to flags.
- overflow set on write_enable && fifo_full; underflow set on read_enable && fifo_empty. Held until err_clear. Same-cycle set and err_clear → flag set (error wins).
- Memory contents are not reset; only pointers, count, flags, read_data, read_valid.

## Timing
- Reset (reset_n low, async): fifo_count 0, fifo_empty 1, fifo_full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, read_valid 0, read_data 0, pointers 0. Reset mid-operation discards all contents; first edge after release behaves as empty FIFO.
- Flags/count reflect an accepted op one cycle after the enabling edge (same edge as pointer update).
- Write-to-read: a word written at edge N is readable (fifo_empty 0) from edge N+1.
- Full throughput: one write and one read per cycle sustained with no bubbles.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through. read_data = mem[rd_ptr] whenever !fifo_empty; read_valid = !fifo_empty; read_enable acknowledges/pops the shown word. Zero-cycle read latency.
- Not defined: registered read. On rd_ok at edge N, read_data loads mem[rd_ptr] at edge N and read_valid is 1 for the following cycle only; read_data holds its value otherwise. One-cycle read latency.

## Test plan
- Reset, write 0x01..0x10 into DEPTH=16 → fifo_full 1, fifo_count 16, almost_full from count 14; 17th write → rejected, overflow 1, contents unchanged.
- Drain all 16 → data 0x01..0x10 in order, fifo_empty 1; extra read → underflow 1, read_valid 0; err_clear → both sticky flags 0.
- Simultaneous write+read at count 8 for 40 cycles → count stays 8, pointers wrap ≥2 times, output order matches input.
- Full + both enables → read pops oldest, write rejected, overflow 1, count 15; empty + both → write accepted, underflow 1, count 1.
- reset_n pulsed low mid-burst at count 9 → all outputs at reset values immediately (async), next write/read returns new data only.
- Both configurations: single write 0xA5 then read → FWFT shows 0xA5 with read_valid 1 one cycle after write; registered mode shows 0xA5 with read_valid 1 one cycle after read_enable.
